// File: rtl/vision_pkg.sv
// Shared pixel/window types for the vision pipeline (line_buffer, window, filter stages).
package vision_pkg;

    localparam int PIX_W = 8;

    typedef logic [PIX_W-1:0] pixel_t;
    typedef pixel_t window_t [0:8];

    // Flat index of the window cell at row r (0 = top/oldest row), column c (0 = left/oldest).
    function automatic int WIN_IDX(input int r, input int c);
        return r * 3 + c;
    endfunction

endpackage

// File: rtl/sliding_window_3x3_raster_pos_counter.sv
// Raster x/y position tracker with wrap, frame resync and last-pixel flag.
// pos_x/pos_y give the position of the pixel presented this cycle (resync already applied).
module raster_pos_counter #(
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    localparam int XW = $clog2(IMAGE_WIDTH),
    localparam int YW = $clog2(IMAGE_HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_start,
    input  logic          advance,
    output logic [XW-1:0] pos_x,
    output logic [YW-1:0] pos_y,
    output logic          last_pixel
);

    localparam logic [XW-1:0] X_LAST = XW'(IMAGE_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMAGE_HEIGHT - 1);
    localparam logic [XW-1:0] X_ONE  = XW'(32'd1);
    localparam logic [YW-1:0] Y_ONE  = YW'(32'd1);

    logic [XW-1:0] x_r;
    logic [YW-1:0] y_r;
    logic [XW-1:0] x_nxt_s;
    logic [YW-1:0] y_nxt_s;

    // Effective position of the current pixel; a resync makes it (0,0).
    always_comb begin
        if (frame_start) begin
            pos_x      = '0;
            pos_y      = '0;
            last_pixel = 1'b0;
        end else begin
            pos_x      = x_r;
            pos_y      = y_r;
            last_pixel = (x_r == X_LAST) && (y_r == Y_LAST);
        end
    end

    // Next position: resync beats normal wrap; an accepted resync pixel occupies (0,0).
    always_comb begin
        x_nxt_s = x_r;
        y_nxt_s = y_r;
        if (frame_start) begin
            x_nxt_s = advance ? X_ONE : '0;
            y_nxt_s = '0;
        end else if (advance) begin
            if (x_r == X_LAST) begin
                x_nxt_s = '0;
                y_nxt_s = (y_r == Y_LAST) ? '0 : (y_r + Y_ONE);
            end else begin
                x_nxt_s = x_r + X_ONE;
            end
        end else begin
            x_nxt_s = x_r;
            y_nxt_s = y_r;
        end
    end

    // Position state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r <= '0;
            y_r <= '0;
        end else begin
            x_r <= x_nxt_s;
            y_r <= y_nxt_s;
        end
    end

endmodule

// File: rtl/sliding_window_3x3.sv
// Assembles a registered 3x3 neighbourhood from the line buffer's aligned column and flags
// fully interior windows, their centre coordinate and the last window of each frame.
module sliding_window_3x3
    import vision_pkg::*;
#(
    parameter int DATA_WIDTH   = PIX_W,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    localparam int XW = $clog2(IMAGE_WIDTH),
    localparam int YW = $clog2(IMAGE_HEIGHT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_start,
    input  logic                    pixel_valid,
    input  logic [DATA_WIDTH-1:0]   pixel_in,
    input  logic [2*DATA_WIDTH-1:0] line_in,
    output logic [9*DATA_WIDTH-1:0] window_out,
    output logic                    window_valid,
    output logic [XW-1:0]           center_x,
    output logic [YW-1:0]           center_y,
    output logic                    frame_done
);

    localparam logic [XW-1:0] X_TWO = XW'(32'd2);
    localparam logic [YW-1:0] Y_TWO = YW'(32'd2);
    localparam logic [XW-1:0] X_ONE = XW'(32'd1);
    localparam logic [YW-1:0] Y_ONE = YW'(32'd1);

    logic [DATA_WIDTH-1:0] win_r [0:8];
    logic [DATA_WIDTH-1:0] col_s [0:2];
    logic [XW-1:0]         pos_x_s;
    logic [YW-1:0]         pos_y_s;
    logic                  last_pixel_s;
    logic                  interior_s;
    logic                  window_valid_r;
    logic                  frame_done_r;
    logic [XW-1:0]         center_x_r;
    logic [YW-1:0]         center_y_r;

    raster_pos_counter #(
        .IMAGE_WIDTH (IMAGE_WIDTH),
        .IMAGE_HEIGHT(IMAGE_HEIGHT)
    ) u_pos (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .advance    (pixel_valid),
        .pos_x      (pos_x_s),
        .pos_y      (pos_y_s),
        .last_pixel (last_pixel_s)
    );

    // Incoming column, top (row y-2) to bottom (row y), and the interior test for it.
    always_comb begin
        col_s[0]   = line_in[2*DATA_WIDTH-1:DATA_WIDTH];
        col_s[1]   = line_in[DATA_WIDTH-1:0];
        col_s[2]   = pixel_in;
        interior_s = (pos_x_s >= X_TWO) && (pos_y_s >= Y_TWO);
    end

    // Column shift register forming the 3x3 window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) begin
                win_r[k] <= '0;
            end
        end else if (pixel_valid) begin
            for (int r = 0; r < 3; r++) begin
                win_r[WIN_IDX(r, 0)] <= win_r[WIN_IDX(r, 1)];
                win_r[WIN_IDX(r, 1)] <= win_r[WIN_IDX(r, 2)];
                win_r[WIN_IDX(r, 2)] <= col_s[r];
            end
        end
    end

    // Valid/centre/frame_done registers; both flags drop on any idle cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window_valid_r <= 1'b0;
            frame_done_r   <= 1'b0;
            center_x_r     <= '0;
            center_y_r     <= '0;
        end else begin
            window_valid_r <= pixel_valid && interior_s;
            frame_done_r   <= pixel_valid && last_pixel_s;
            if (pixel_valid && interior_s) begin
                center_x_r <= pos_x_s - X_ONE;
                center_y_r <= pos_y_s - Y_ONE;
            end
        end
    end

    for (genvar g = 0; g < 9; g++) begin : g_flat
        assign window_out[g*DATA_WIDTH +: DATA_WIDTH] = win_r[g];
    end

    assign window_valid = window_valid_r;
    assign frame_done   = frame_done_r;
    assign center_x     = center_x_r;
    assign center_y     = center_y_r;

endmodule

// File: tb/tb_sliding_window_3x3.sv
// Randomised bench for sliding_window_3x3 against a 2-D image model of the raster stream.
module tb_sliding_window_3x3;
    import vision_pkg::*;

    localparam int DW = 8;
    localparam int W  = 10;
    localparam int H  = 5;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);
    localparam int WINDOWS_PER_FRAME = (W - 2) * (H - 2);

    logic              clk = 1'b0;
    logic              rst;
    logic              frame_start;
    logic              pixel_valid;
    logic [DW-1:0]     pixel_in;
    logic [2*DW-1:0]   line_in;
    logic [9*DW-1:0]   window_out;
    logic              window_valid;
    logic [XW-1:0]     center_x;
    logic [YW-1:0]     center_y;
    logic              frame_done;

    sliding_window_3x3 #(
        .DATA_WIDTH  (DW),
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .pixel_valid (pixel_valid),
        .pixel_in    (pixel_in),
        .line_in     (line_in),
        .window_out  (window_out),
        .window_valid(window_valid),
        .center_x    (center_x),
        .center_y    (center_y),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int     errors = 0;
    int     checks = 0;
    pixel_t img [0:H-1][0:W-1];
    int     mdl_n   = 0;
    int     win_cnt = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [9*DW-1:0] pack9(input int v [0:8]);
        logic [9*DW-1:0] p;
        for (int k = 0; k < 9; k++) p[k*DW +: DW] = DW'(v[k]);
        return p;
    endfunction

    // One clock cycle: drive a column (or a gap / bare resync), then compare with the model.
    task automatic step(input bit v, input bit fs, input pixel_t pix);
        int x, y;
        bit exp_v, exp_d;
        logic [9*DW-1:0] exp_win;
        @(negedge clk);
        if (fs) begin
            mdl_n   = 0;
            win_cnt = 0;
        end
        x = mdl_n % W;
        y = mdl_n / W;
        pixel_valid = v;
        frame_start = fs;
        pixel_in    = pix;
        line_in     = {(y >= 2) ? img[y-2][x] : pixel_t'($urandom),
                       (y >= 1) ? img[y-1][x] : pixel_t'($urandom)};
        @(posedge clk);
        #1;
        pixel_valid = 1'b0;
        frame_start = 1'b0;
        exp_v = 1'b0;
        exp_d = 1'b0;
        if (v) begin
            img[y][x] = pix;
            exp_v = (x >= 2) && (y >= 2);
            exp_d = (mdl_n == W * H - 1);
            mdl_n = (mdl_n + 1) % (W * H);
        end
        check_eq("window_valid", window_valid, exp_v);
        check_eq("frame_done", frame_done, exp_d);
        if (exp_v) begin
            win_cnt++;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    exp_win[WIN_IDX(r, c)*DW +: DW] = img[y-2+r][x-2+c];
            check_eq("window_out", window_out, exp_win);
            check_eq("center_x", center_x, x - 1);
            check_eq("center_y", center_y, y - 1);
        end
        if (exp_d) begin
            check_eq("windows_per_frame", win_cnt, WINDOWS_PER_FRAME);
            win_cnt = 0;
        end
    endtask

    task automatic check_cleared(input string tag);
        check_eq({tag, "_valid"}, window_valid, 1'b0);
        check_eq({tag, "_window"}, window_out, '0);
        check_eq({tag, "_cx"}, center_x, '0);
        check_eq({tag, "_cy"}, center_y, '0);
        check_eq({tag, "_done"}, frame_done, 1'b0);
    endtask

    int first_w [0:8] = '{0, 1, 2, 10, 11, 12, 20, 21, 22};
    int last_w  [0:8] = '{27, 28, 29, 37, 38, 39, 47, 48, 49};
    int sync_w  [0:8] = '{13, 14, 15, 23, 24, 25, 33, 34, 35};

    initial begin
        rst         = 1'b1;
        frame_start = 1'b0;
        pixel_valid = 1'b0;
        pixel_in    = '0;
        line_in     = '0;
        #12;
        check_cleared("reset");
        @(negedge clk);
        rst = 1'b0;

        // Two back-to-back frames of index-valued pixels.
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b0, pixel_t'(i));
            if (i == 22) begin
                check_eq("first_window", window_out, pack9(first_w));
                check_eq("first_centre", {center_x, center_y}, {4'd1, 3'd1});
            end
            if (i == 49) begin
                check_eq("last_window", window_out, pack9(last_w));
                check_eq("last_centre", {center_x, center_y}, {4'd8, 3'd3});
            end
        end

        // Same frame with random gaps on roughly half the cycles.
        for (int i = 0; i < 50; i++) begin
            while ($urandom_range(1) == 1) step(1'b0, 1'b0, pixel_t'($urandom));
            step(1'b1, 1'b0, pixel_t'(i));
        end

        // Asynchronous reset mid-frame, then restart from 0.
        for (int i = 0; i < 28; i++) step(1'b1, 1'b0, pixel_t'(i));
        #2 rst = 1'b1;
        #1 check_cleared("midreset");
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        mdl_n   = 0;
        win_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step(1'b1, 1'b0, pixel_t'(i));
            if (i == 22) check_eq("post_reset_window", window_out, pack9(first_w));
        end

        // Resync on pixel 13 mid-frame; the next frame completes at 62.
        for (int i = 0; i < 63; i++) begin
            step(1'b1, (i == 13), pixel_t'(i));
            if (i == 35) begin
                check_eq("resync_window", window_out, pack9(sync_w));
                check_eq("resync_centre", {center_x, center_y}, {4'd1, 3'd1});
            end
        end

        // Partial frame, bare resync, then random-valued frames with gaps.
        for (int i = 0; i < 17; i++) step(1'b1, 1'b0, pixel_t'($urandom));
        step(1'b0, 1'b1, pixel_t'($urandom));
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(3) == 0) step(1'b0, 1'b0, pixel_t'($urandom));
            step(1'b1, 1'b0, pixel_t'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
